// File: rtl/uart_tx.sv
// UART transmitter: 8-deep TX FIFO feeding an 8N1 serialiser with programmable bit period.
// The line is driven from a flop whose value is derived from the next state.
module uart_tx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_fifo_write_i,
  input  logic [DATA_WIDTH-1:0] tx_fifo_data_i,
  output logic                  tx_fifo_full_o,
  output logic                  tx_fifo_empty_o,
  output logic                  tx_fifo_mark_o,
  input  logic [2:0]            tx_watermark_i,
  input  logic                  tx_en_i,
  input  logic [15:0]           baud_rate_i,
  output logic                  tx_busy_o,
  output logic                  tx_pin_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]       r_count;
  logic                  r_mark;
  logic                  r_pin;
  state_e                r_state, w_state_d;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_d;
  logic [3:0]            r_bit_cnt, w_bit_cnt_d;
  logic [15:0]           r_baud_cnt, w_baud_cnt_d;
  logic                  w_pin_d;
  logic                  w_full, w_empty, w_push, w_pop;

  assign w_full  = (r_count == CntW'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = tx_fifo_write_i && !w_full;

  assign tx_fifo_full_o  = w_full;
  assign tx_fifo_empty_o = w_empty;
  assign tx_fifo_mark_o  = r_mark;
  assign tx_busy_o       = (r_state != StIdle);
  assign tx_pin_o        = r_pin;

  always_comb begin
    w_state_d    = r_state;
    w_shift_d    = r_shift;
    w_bit_cnt_d  = r_bit_cnt;
    w_baud_cnt_d = r_baud_cnt;
    w_pop        = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (tx_en_i && !w_empty) begin
          w_pop        = 1'b1;
          w_shift_d    = r_mem[r_rd_ptr];
          w_bit_cnt_d  = 4'(DATA_WIDTH);
          w_baud_cnt_d = baud_rate_i;
          w_state_d    = StStart;
        end
      end
      StStart: begin
        if (r_baud_cnt == '0) begin
          w_baud_cnt_d = baud_rate_i;
          w_state_d    = StData;
        end else begin
          w_baud_cnt_d = r_baud_cnt - 16'd1;
        end
      end
      StData: begin
        if (r_baud_cnt == '0) begin
          w_shift_d    = r_shift >> 1;
          w_bit_cnt_d  = r_bit_cnt - 4'd1;
          w_baud_cnt_d = baud_rate_i;
          if (r_bit_cnt == 4'd1) w_state_d = StStop;
        end else begin
          w_baud_cnt_d = r_baud_cnt - 16'd1;
        end
      end
      StStop: begin
        if (r_baud_cnt == '0) w_state_d = StIdle;
        else w_baud_cnt_d = r_baud_cnt - 16'd1;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Pin follows the next state so the line changes on the same edge as the FSM.
  always_comb begin
    w_pin_d = 1'b1;
    unique case (w_state_d)
      StStart: w_pin_d = 1'b0;
      StData:  w_pin_d = w_shift_d[0];
      default: w_pin_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= tx_fifo_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_baud_cnt <= '0;
      r_pin      <= 1'b1;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_mark     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_shift    <= w_shift_d;
      r_bit_cnt  <= w_bit_cnt_d;
      r_baud_cnt <= w_baud_cnt_d;
      r_pin      <= w_pin_d;
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CntW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CntW'(1);
      // Watermark 0 can never be exceeded from below, so mark stays low.
      r_mark <= (32'(r_count) < 32'(tx_watermark_i));
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: literal frame vectors, directed corner sequences, and random traffic
// checked every cycle against a timeline model of the FIFO and frames.
module tb_uart_tx;

  localparam int Depth = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr = 1'b0;
  logic [7:0]  din = '0;
  logic        en = 1'b0;
  logic [2:0]  wm = '0;
  logic [15:0] baud = '0;
  logic        full, empty, mark, busy, pin;

  uart_tx #(.DATA_WIDTH(8), .FIFO_DEPTH(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .tx_fifo_write_i (wr),
    .tx_fifo_data_i  (din),
    .tx_fifo_full_o  (full),
    .tx_fifo_empty_o (empty),
    .tx_fifo_mark_o  (mark),
    .tx_watermark_i  (wm),
    .tx_en_i         (en),
    .baud_rate_i     (baud),
    .tx_busy_o       (busy),
    .tx_pin_o        (pin)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: bytes waiting, and the active frame as a window of cycles [fb, fe).
  logic [7:0] mq[$];
  int         cyc = 0;
  int         fb = 0;
  int         fe = 0;
  int         m_b = 0;
  logic [7:0] m_byte = '0;
  logic       m_mark = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    int   cnt;
    int   k;
    logic e_pin;
    cnt = mq.size();
    if (rst) begin
      mq.delete();
      fb = 0;
      fe = 0;
      m_mark = 1'b0;
    end else begin
      if (cyc >= fe && en && cnt > 0) begin
        m_byte = mq.pop_front();
        m_b = int'(baud);
        fb = cyc + 1;
        fe = fb + 10 * (m_b + 1);
      end
      if (wr && cnt < Depth) mq.push_back(din);
      m_mark = (cnt < int'(wm));
    end
    @(posedge clk);
    #1;
    cyc++;
    e_pin = 1'b1;
    if (cyc >= fb && cyc < fe) begin
      k = (cyc - fb) / (m_b + 1);
      if (k == 0) e_pin = 1'b0;
      else if (k <= 8) e_pin = m_byte[k-1];
    end
    check("m_pin", 16'(pin), 16'(e_pin));
    check("m_busy", 16'(busy), 16'(cyc >= fb && cyc < fe));
    check("m_empty", 16'(empty), 16'(mq.size() == 0));
    check("m_full", 16'(full), 16'(mq.size() == Depth));
    check("m_mark", 16'(mark), 16'(m_mark));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr = 1'b0;
    en = 1'b0;
    step();
    rst = 1'b0;
    check("rst_pin", 16'(pin), 16'd1);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_full", 16'(full), 16'd0);
    check("rst_empty", 16'(empty), 16'd1);
    check("rst_mark", 16'(mark), 16'd0);
  endtask

  typedef struct {
    logic [7:0]  data;
    logic [15:0] baud;
    logic [9:0]  pat;  // pat[0] is the first bit on the line
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rises;
    int btot;
    int first_b;
    int last_b;
    logic prev;

    vecs[0] = '{data: 8'hA5, baud: 16'd3, pat: 10'b1101001010};
    vecs[1] = '{data: 8'h00, baud: 16'd0, pat: 10'b1000000000};
    vecs[2] = '{data: 8'hFF, baud: 16'd1, pat: 10'b1111111110};
    vecs[3] = '{data: 8'h3C, baud: 16'd2, pat: 10'b1001111000};
    vecs[4] = '{data: 8'h81, baud: 16'd5, pat: 10'b1100000010};

    @(posedge clk);
    #1;

    // Single frames against literal line patterns.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      baud = vecs[v].baud;
      wm = 3'd0;
      en = 1'b1;
      wr = 1'b1;
      din = vecs[v].data;
      step();
      wr = 1'b0;
      check("pre_start_pin", 16'(pin), 16'd1);
      step();
      for (int i = 0; i < 10; i++) begin
        for (int j = 0; j <= int'(vecs[v].baud); j++) begin
          check("vec_pin", 16'(pin), 16'(vecs[v].pat[i]));
          check("vec_busy", 16'(busy), 16'd1);
          step();
        end
      end
      check("vec_end_busy", 16'(busy), 16'd0);
      check("vec_end_pin", 16'(pin), 16'd1);
      check("vec_wm0_mark", 16'(mark), 16'd0);
    end

    // Fill past full with transmit disabled, then drain.
    do_reset();
    baud = 16'd1;
    for (int i = 0; i < 9; i++) begin
      wr = 1'b1;
      din = 8'(i);
      step();
      if (i == 7) check("fill_full", 16'(full), 16'd1);
    end
    wr = 1'b0;
    step();
    check("fill_hold_full", 16'(full), 16'd1);
    check("fill_hold_busy", 16'(busy), 16'd0);
    en = 1'b1;
    rises = 0;
    prev = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (busy && !prev) rises++;
      prev = busy;
    end
    check("drain_frames", 16'(rises), 16'd8);
    check("drain_empty", 16'(empty), 16'd1);

    // Watermark lag.
    do_reset();
    wm = 3'd4;
    for (int i = 0; i < 3; i++) begin
      wr = 1'b1;
      din = 8'h40 + 8'(i);
      step();
    end
    wr = 1'b0;
    step();
    check("wm_low_mark", 16'(mark), 16'd1);
    for (int i = 0; i < 2; i++) begin
      wr = 1'b1;
      din = 8'h50 + 8'(i);
      step();
    end
    wr = 1'b0;
    step();
    check("wm_high_mark", 16'(mark), 16'd0);

    // Back-to-back frames at B=0 with a single idle cycle between them.
    do_reset();
    baud = 16'd0;
    wm = 3'd0;
    for (int i = 0; i < 3; i++) begin
      wr = 1'b1;
      din = 8'hC3 ^ 8'(i * 17);
      step();
    end
    wr = 1'b0;
    en = 1'b1;
    rises = 0;
    btot = 0;
    first_b = -1;
    last_b = -1;
    prev = 1'b0;
    for (int i = 0; i < 45; i++) begin
      step();
      if (busy) begin
        btot++;
        if (first_b < 0) first_b = i;
        last_b = i;
      end
      if (busy && !prev) rises++;
      prev = busy;
    end
    check("b2b_frames", 16'(rises), 16'd3);
    check("b2b_busy_total", 16'(btot), 16'd30);
    check("b2b_span", 16'(last_b - first_b + 1), 16'd32);

    // Reset in the middle of data bit 3.
    do_reset();
    baud = 16'd2;
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr = 1'b1;
      din = 8'hF0 + 8'(i);
      step();
    end
    wr = 1'b0;
    for (int i = 0; i < 100 && !(fe > 0 && cyc == fb + 4 * 3 + 1); i++) step();
    check("midrst_reached", 16'(cyc == fb + 13), 16'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_pin", 16'(pin), 16'd1);
    check("midrst_busy", 16'(busy), 16'd0);
    check("midrst_empty", 16'(empty), 16'd1);
    check("midrst_mark", 16'(mark), 16'd0);
    for (int i = 0; i < 30; i++) begin
      step();
      check("midrst_quiet", 16'(pin), 16'd1);
    end

    // Write while full in the same cycle as a pop.
    do_reset();
    baud = 16'd0;
    for (int i = 0; i < 8; i++) begin
      wr = 1'b1;
      din = 8'h10 + 8'(i);
      step();
    end
    wr = 1'b0;
    step();
    check("wfp_full", 16'(full), 16'd1);
    en = 1'b1;
    wr = 1'b1;
    din = 8'hEE;
    step();
    wr = 1'b0;
    check("wfp_after_pop_full", 16'(full), 16'd0);
    wr = 1'b1;
    din = 8'h55;
    step();
    wr = 1'b0;
    check("wfp_refill_full", 16'(full), 16'd1);
    for (int i = 0; i < 120; i++) step();
    check("wfp_drain_empty", 16'(empty), 16'd1);

    // Random traffic against the model.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      baud = 16'($urandom_range(0, 3));
      for (int i = 0; i < 2000; i++) begin
        wr = ($urandom_range(0, 3) == 0);
        din = 8'($urandom);
        en = ($urandom_range(0, 15) != 0);
        wm = 3'($urandom);
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
